// File: rtl/beam_acq_seq_if.sv
// Control/status bundle between the acquisition sequencer and the beamformer front end.
interface beam_acq_seq_if #(
   parameter int ADDR_WIDTH = 12,
   parameter int LINE_WIDTH = 8,
   parameter int DEAD_WIDTH = 10
);
   logic                  start;
   logic                  abort;
   logic                  tx_trig;
   logic [LINE_WIDTH-1:0] cfg_num_lines;
   logic [ADDR_WIDTH-1:0] cfg_num_samples;
   logic [DEAD_WIDTH-1:0] cfg_dead;
   logic                  tx_req;
   logic                  rd_en;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic [LINE_WIDTH-1:0] line_idx;
   logic                  sum_valid;
   logic                  line_done;
   logic                  frame_done;
   logic                  busy;

   modport master (
      input  start, abort, tx_trig, cfg_num_lines, cfg_num_samples, cfg_dead,
      output tx_req, rd_en, rd_addr, line_idx, sum_valid, line_done, frame_done, busy
   );

   modport slave (
      output start, abort, tx_trig, cfg_num_lines, cfg_num_samples, cfg_dead,
      input  tx_req, rd_en, rd_addr, line_idx, sum_valid, line_done, frame_done, busy
   );
endinterface

// File: rtl/beam_acq_seq.sv
// Per-frame receive acquisition sequencer: tx request, trigger wait, dead time,
// sample address streaming, and a rd_en delay line that marks valid summer output.
module beam_acq_seq #(
   parameter int ADDR_WIDTH = 12,
   parameter int LINE_WIDTH = 8,
   parameter int DEAD_WIDTH = 10,
   parameter int PIPE_LAT   = 2
) (
   input  logic           clk,
   input  logic           reset,
   beam_acq_seq_if.master bus
);
   localparam int DRW = $clog2(PIPE_LAT + 2);

   typedef enum logic [2:0] {S_IDLE, S_TXREQ, S_ARM, S_DEAD, S_ACQ, S_DRAIN} state_t;

   state_t                r_state;
   logic [LINE_WIDTH-1:0] r_lines;
   logic [ADDR_WIDTH-1:0] r_samples;
   logic [DEAD_WIDTH-1:0] r_dead;
   logic [DEAD_WIDTH-1:0] r_dead_cnt;
   logic [DRW-1:0]        r_drain;
   logic [LINE_WIDTH-1:0] r_line_idx;
   logic [ADDR_WIDTH-1:0] r_rd_addr;
   logic                  r_tx_req;
   logic                  r_rd_en;
   logic                  r_line_done;
   logic                  r_frame_done;
   logic                  r_busy;
   logic [PIPE_LAT:1]     r_vld_pipe;

   logic w_last_addr;
   logic w_last_line;

   assign w_last_addr = (r_rd_addr == r_samples - ADDR_WIDTH'(1));
   assign w_last_line = (r_line_idx == r_lines - LINE_WIDTH'(1));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_lines      <= '0;
         r_samples    <= '0;
         r_dead       <= '0;
         r_dead_cnt   <= '0;
         r_drain      <= '0;
         r_line_idx   <= '0;
         r_rd_addr    <= '0;
         r_tx_req     <= 1'b0;
         r_rd_en      <= 1'b0;
         r_line_done  <= 1'b0;
         r_frame_done <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         r_tx_req     <= 1'b0;
         r_line_done  <= 1'b0;
         r_frame_done <= 1'b0;
         if (bus.abort) begin
            r_state    <= S_IDLE;
            r_rd_en    <= 1'b0;
            r_busy     <= 1'b0;
            r_line_idx <= '0;
            r_rd_addr  <= '0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (bus.start) begin
                     r_lines    <= bus.cfg_num_lines;
                     r_samples  <= bus.cfg_num_samples;
                     r_dead     <= bus.cfg_dead;
                     r_line_idx <= '0;
                     // An empty frame completes immediately without touching the front end
                     if (bus.cfg_num_lines == '0 || bus.cfg_num_samples == '0) begin
                        r_frame_done <= 1'b1;
                     end else begin
                        r_state  <= S_TXREQ;
                        r_tx_req <= 1'b1;
                        r_busy   <= 1'b1;
                     end
                  end
               end
               S_TXREQ: r_state <= S_ARM;
               S_ARM: begin
                  if (bus.tx_trig) begin
                     if (r_dead == '0) begin
                        r_state   <= S_ACQ;
                        r_rd_en   <= 1'b1;
                        r_rd_addr <= '0;
                     end else begin
                        r_dead_cnt <= r_dead;
                        r_state    <= S_DEAD;
                     end
                  end
               end
               S_DEAD: begin
                  if (r_dead_cnt == DEAD_WIDTH'(1)) begin
                     r_state   <= S_ACQ;
                     r_rd_en   <= 1'b1;
                     r_rd_addr <= '0;
                  end else begin
                     r_dead_cnt <= r_dead_cnt - DEAD_WIDTH'(1);
                  end
               end
               S_ACQ: begin
                  if (w_last_addr) begin
                     r_state   <= S_DRAIN;
                     r_rd_en   <= 1'b0;
                     r_rd_addr <= '0;
                     r_drain   <= DRW'(PIPE_LAT);
                     if (PIPE_LAT == 1) begin
                        r_line_done  <= 1'b1;
                        r_frame_done <= w_last_line;
                     end
                  end else begin
                     r_rd_addr <= r_rd_addr + ADDR_WIDTH'(1);
                  end
               end
               S_DRAIN: begin
                  // done pulses are staged one cycle early so they land on the last drain cycle
                  if (r_drain == DRW'(1)) begin
                     if (w_last_line) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                     end else begin
                        r_line_idx <= r_line_idx + LINE_WIDTH'(1);
                        r_state    <= S_TXREQ;
                        r_tx_req   <= 1'b1;
                     end
                  end else begin
                     r_drain <= r_drain - DRW'(1);
                     if (r_drain == DRW'(2)) begin
                        r_line_done  <= 1'b1;
                        r_frame_done <= w_last_line;
                     end
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   // rd_en delay line matching buffer read + summer latency
   always_ff @(posedge clk) begin
      if (reset || bus.abort) begin
         r_vld_pipe <= '0;
      end else begin
         r_vld_pipe[1] <= r_rd_en;
         for (int k = 2; k <= PIPE_LAT; k++) r_vld_pipe[k] <= r_vld_pipe[k-1];
      end
   end

   assign bus.tx_req     = r_tx_req;
   assign bus.rd_en      = r_rd_en;
   assign bus.rd_addr    = r_rd_addr;
   assign bus.line_idx   = r_line_idx;
   assign bus.sum_valid  = r_vld_pipe[PIPE_LAT];
   assign bus.line_done  = r_line_done;
   assign bus.frame_done = r_frame_done;
   assign bus.busy       = r_busy;
endmodule

// File: tb/tb_beam_acq_seq.sv
// Scoreboard bench for beam_acq_seq: expected output events queued per frame, monitor pops on each output.
module tb_beam_acq_seq;
   localparam int AW = 12, LW = 8, DW = 10, PL = 2;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   beam_acq_seq_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .DEAD_WIDTH(DW)) bus ();

   beam_acq_seq #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .DEAD_WIDTH(DW), .PIPE_LAT(PL)) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   typedef struct {int c; int a; int b;} ev_t;
   ev_t q_tx[$], q_rd[$], q_sv[$], q_ld[$], q_fd[$], q_bz[$];

   task automatic chk(input string nm, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d at cycle %0d", nm, got, exp, cyc);
      end
   endtask

   task automatic exp_ev(input int k, input int c, input int a, input int b, input int kc);
      ev_t e;
      e.c = c; e.a = a; e.b = b;
      if (c > kc) return;
      case (k)
         0: q_tx.push_back(e);
         1: q_rd.push_back(e);
         2: q_sv.push_back(e);
         3: q_ld.push_back(e);
         4: q_fd.push_back(e);
         default: q_bz.push_back(e);
      endcase
   endtask

   task automatic goto(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   // monitor: one expected event consumed per observed output strobe
   logic prev_busy = 1'b0;
   always @(negedge clk) begin : mon
      ev_t e;
      if (cyc > 0) begin
         if (bus.tx_req) begin
            if (q_tx.size() == 0) chk("tx_req_unexpected", cyc, -1);
            else begin e = q_tx.pop_front(); chk("tx_req_cycle", cyc, e.c); end
         end
         if (bus.rd_en) begin
            if (q_rd.size() == 0) chk("rd_en_unexpected", cyc, -1);
            else begin
               e = q_rd.pop_front();
               chk("rd_cycle", cyc, e.c);
               chk("rd_addr", int'(bus.rd_addr), e.a);
               chk("rd_line_idx", int'(bus.line_idx), e.b);
            end
         end
         if (bus.sum_valid) begin
            if (q_sv.size() == 0) chk("sum_valid_unexpected", cyc, -1);
            else begin e = q_sv.pop_front(); chk("sum_valid_cycle", cyc, e.c); end
         end
         if (bus.line_done) begin
            if (q_ld.size() == 0) chk("line_done_unexpected", cyc, -1);
            else begin
               e = q_ld.pop_front();
               chk("line_done_cycle", cyc, e.c);
               chk("line_done_idx", int'(bus.line_idx), e.b);
            end
         end
         if (bus.frame_done) begin
            if (q_fd.size() == 0) chk("frame_done_unexpected", cyc, -1);
            else begin e = q_fd.pop_front(); chk("frame_done_cycle", cyc, e.c); end
         end
         if (bus.busy !== prev_busy) begin
            if (q_bz.size() == 0) chk("busy_unexpected_change", cyc, -1);
            else begin
               e = q_bz.pop_front();
               chk("busy_cycle", cyc, e.c);
               chk("busy_value", int'(bus.busy), e.a);
            end
         end
         prev_busy = bus.busy;
      end
   end

   task automatic chk_all_zero(input string tag);
      chk({tag, "_tx_req"}, int'(bus.tx_req), 0);
      chk({tag, "_rd_en"}, int'(bus.rd_en), 0);
      chk({tag, "_rd_addr"}, int'(bus.rd_addr), 0);
      chk({tag, "_line_idx"}, int'(bus.line_idx), 0);
      chk({tag, "_sum_valid"}, int'(bus.sum_valid), 0);
      chk({tag, "_line_done"}, int'(bus.line_done), 0);
      chk({tag, "_frame_done"}, int'(bus.frame_done), 0);
      chk({tag, "_busy"}, int'(bus.busy), 0);
   endtask

   // One frame: tx_trig 5 cycles after each tx_req. kl>=0 kills line kl at T+koff
   // (abort, or reset when krst). noise pulses ignored start/tx_trig and changes cfg.
   task automatic frame(input int L, input int N, input int D, input bit noise,
                        input int kl, input int koff, input bit krst);
      int s, t, a, kc;
      s = cyc;
      kc = 1 << 30;
      bus.cfg_num_lines   = LW'(L);
      bus.cfg_num_samples = AW'(N);
      bus.cfg_dead        = DW'(D);
      bus.start = 1'b1;
      if (L == 0 || N == 0) begin
         exp_ev(4, s + 1, 0, 0, kc);
         goto(s + 1);
         bus.start = 1'b0;
         goto(s + 4);
         return;
      end
      exp_ev(5, s + 1, 1, 0, kc);
      t = s + 1;
      for (int l = 0; l < L; l++) begin
         if (l == kl) kc = t + koff;
         exp_ev(0, t, 0, 0, kc);
         a = t + 6 + D;
         for (int i = 0; i < N; i++) begin
            exp_ev(1, a + i, i, l, kc);
            exp_ev(2, a + PL + i, 0, 0, kc);
         end
         exp_ev(3, a + N + PL - 1, 0, l, kc);
         if (l == L - 1) begin
            exp_ev(4, a + N + PL - 1, 0, 0, kc);
            exp_ev(5, a + N + PL, 0, 0, kc);
         end
         t = a + N + PL;
      end
      if (kl >= 0) exp_ev(5, kc + 1, 0, 0, kc + 1);

      goto(s + 1);
      bus.start = 1'b0;
      if (noise) begin
         bus.cfg_num_lines = LW'(5); bus.cfg_num_samples = AW'(9); bus.cfg_dead = '0;
      end
      t = s + 1;
      for (int l = 0; l < L; l++) begin
         a = t + 6 + D;
         if (noise) begin goto(t + 2); bus.start = 1'b1; goto(t + 3); bus.start = 1'b0; end
         goto(t + 5); bus.tx_trig = 1'b1;
         goto(t + 6); bus.tx_trig = 1'b0;
         if (noise && D >= 2) begin goto(t + 7); bus.tx_trig = 1'b1; goto(t + 8); bus.tx_trig = 1'b0; end
         if (l == kl) begin
            goto(t + koff);
            if (krst) reset = 1'b1; else bus.abort = 1'b1;
            goto(t + koff + 1);
            reset = 1'b0; bus.abort = 1'b0;
            chk_all_zero(krst ? "reset_kill" : "abort_kill");
            goto(t + koff + 4);
            return;
         end
         if (noise) begin
            goto(a + 1); bus.start = 1'b1;
            goto(a + 2); bus.start = 1'b0; bus.tx_trig = 1'b1;
            goto(a + 3); bus.tx_trig = 1'b0;
         end
         t = a + N + PL;
      end
      goto(t + 2);
   endtask

   initial begin
      #200000;
      failures++;
      $display("FAIL watchdog got=timeout exp=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      bus.start = 1'b0; bus.abort = 1'b0; bus.tx_trig = 1'b0;
      bus.cfg_num_lines = '0; bus.cfg_num_samples = '0; bus.cfg_dead = '0;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk_all_zero("reset");
      reset = 1'b0;
      goto(cyc + 2);

      frame(2, 4, 3, 1'b0, -1, 0, 1'b0);   // basic frame
      frame(1, 3, 0, 1'b0, -1, 0, 1'b0);   // zero dead time
      frame(0, 8, 3, 1'b0, -1, 0, 1'b0);   // zero lines
      frame(2, 0, 1, 1'b0, -1, 0, 1'b0);   // zero samples
      frame(3, 16, 2, 1'b0, 1, 13, 1'b0);  // abort at rd_addr=5 of line 1
      frame(2, 4, 3, 1'b1, -1, 0, 1'b0);   // restart with ignored inputs
      frame(2, 4, 5, 1'b0, 0, 7, 1'b1);    // reset mid-DEAD
      frame(1, 2, 1, 1'b0, -1, 0, 1'b0);   // clean frame after reset

      goto(cyc + 3);
      chk("pending_tx_req", q_tx.size(), 0);
      chk("pending_rd_en", q_rd.size(), 0);
      chk("pending_sum_valid", q_sv.size(), 0);
      chk("pending_line_done", q_ld.size(), 0);
      chk("pending_frame_done", q_fd.size(), 0);
      chk("pending_busy", q_bz.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
